ringbuffer_readout: RTL and testbench
=====================================

Name: ringbuffer_readout

Overview:
- Read-side controller for the PMT sample ring buffer; the ring buffer is the writer, this block is the reader.
- On a trigger it waits until all post-trigger samples have been written, then freezes writes via wr_hold.
- It reads a LEN-sample window starting PRE samples before the trigger and streams it out on a valid/ready interface toward the event builder.

Parameters:
SIZE, 8, ring buffer address width; depth 2**SIZE
WIDTH, 14, sample width
PRE, 16, samples captured before trigger; 0 <= PRE < LEN
LEN, 64, samples per readout window; LEN <= 2**SIZE-1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
trigger  in  1  single-cycle trigger pulse
wr_ptr  in  SIZE  ring buffer write address (next location to be written)
wr_hold  out  1  registered; gates ring buffer wr_en externally while high
rb_rd_en  out  1  ring buffer read enable
rb_addr  out  SIZE  ring buffer read address
rb_data  in  WIDTH  ring buffer read data; combinational from rb_addr
dout  out  WIDTH  output sample
dout_valid  out  1  output handshake valid
dout_ready  in  1  output handshake ready
dout_last  out  1  marks final sample of window
busy  out  1  high in any state other than IDLE
missed_trig  out  8  count of triggers ignored while busy; saturates at 255

Behaviour:
- Reset (async, active-high):
  - Every output goes to 0; state goes to IDLE.
  - Any window in progress is abandoned and no partial dout_last is emitted.
- States: IDLE, WAIT, READ, DRAIN.
- IDLE:
  - trigger=1 latches start = wr_ptr - PRE (mod 2**SIZE) and end = start + LEN (mod 2**SIZE). Next state is WAIT.
  - The wr_ptr sampled in the trigger cycle is the address of the first post-trigger sample.
- WAIT: when wr_ptr == end, next state is READ and wr_hold is set to 1 on the same edge. rb_addr <= start; the read counter is cleared.
  - A single write landing at address end in the equality cycle is permitted. It lies outside the window.
- READ:
  - rb_rd_en = 1.
  - Load condition: dout_valid=0 or dout_ready=1. On each cycle meeting it:
    - dout <= rb_data, dout_valid <= 1, dout_last <= (count == LEN-1).
    - rb_addr and count increment; rb_addr wraps mod 2**SIZE.
  - After loading the word with count == LEN-1, next state is DRAIN and rb_rd_en goes to 0.
  - When no load occurs, dout, dout_valid and dout_last hold.
- DRAIN:
  - The last word is held until dout_ready=1, at which point dout_valid and dout_last go to 0.
  - wr_hold goes to 0 and state returns to IDLE on that same edge.
- Output handshake rules:
  - dout and dout_last are stable while dout_valid=1 and dout_ready=0.
  - dout_valid never drops without a transfer, except on reset.
- Latency:
  - The first dout_valid is asserted one cycle after READ is entered.
  - With dout_ready held high, one sample transfers per cycle; LEN transfers take LEN cycles plus 1.
- Triggers:
  - A trigger in WAIT, READ or DRAIN increments missed_trig (saturating) and is otherwise ignored.
  - A trigger on the same edge the block returns to IDLE is also counted as missed.
- Wrap-around: start may exceed end numerically. All address arithmetic is modulo 2**SIZE.
- PRE=0: the window begins at the trigger-cycle wr_ptr.

Test Plan:
- Basic window (PRE=16, LEN=64, SIZE=8, ring buffer fed a ramp din = sample index), trigger when wr_ptr=100, dout_ready=1:
  - Reads begin when wr_ptr=148.
  - 64 words, values 84..147, in consecutive cycles.
  - dout_last only on 147; wr_hold high from entry to READ until the last transfer.
- Backpressure, same setup, dout_ready toggled pseudo-randomly:
  - Same 64 values in order, none dropped or duplicated.
  - dout stable whenever valid=1 and ready=0.
- Wrap-around, trigger at wr_ptr=5:
  - start=245; addresses 245..255 then 0..52.
  - Data matches ramp modulo 256; reads begin at wr_ptr=53.
- Triggers while busy: 3 triggers during WAIT and 2 during READ -> missed_trig=5, one window only. Force 300 ignored triggers -> missed_trig=255.
- Reset mid-readout, rst asserted after the 20th transfer:
  - All outputs 0 immediately, without waiting for a clock edge.
  - A new trigger after release yields a complete, correct 64-word window.
- PRE=0, LEN=1, trigger at wr_ptr=10: single word, value 10, with dout_valid=1 and dout_last=1 together.

Source files
------------

// File: rtl/ringbuffer_readout.sv
// Read-side controller for the PMT sample ring buffer: on trigger, waits for the post-trigger
// samples, freezes the writer and streams a fixed window out on a valid/ready interface.
module ringbuffer_readout #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned WIDTH = 14,
  parameter int unsigned PRE   = 16,
  parameter int unsigned LEN   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic [SIZE-1:0]  wr_ptr,
  output logic             wr_hold,
  output logic             rb_rd_en,
  output logic [SIZE-1:0]  rb_addr,
  input  logic [WIDTH-1:0] rb_data,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last,
  output logic             busy,
  output logic [7:0]       missed_trig
);

  typedef enum logic [1:0] {StIdle, StWait, StRead, StDrain} state_e;

  state_e          state;
  logic [SIZE-1:0] start_addr;
  logic [SIZE-1:0] end_addr;
  logic [SIZE-1:0] count;
  logic [SIZE-1:0] trig_start;
  logic            load;
  logic            last_load;

  // Sample at wr_ptr in the trigger cycle is the first post-trigger sample.
  assign trig_start = wr_ptr - SIZE'(PRE);
  assign load       = (state == StRead) && (!dout_valid || dout_ready);
  assign last_load  = load && (count == SIZE'(LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      start_addr  <= '0;
      end_addr    <= '0;
      count       <= '0;
      rb_addr     <= '0;
      rb_rd_en    <= 1'b0;
      wr_hold     <= 1'b0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      dout_last   <= 1'b0;
      busy        <= 1'b0;
      missed_trig <= '0;
    end else begin
      if (trigger && (state != StIdle) && (missed_trig != 8'hff)) begin
        missed_trig <= missed_trig + 8'd1;
      end
      unique case (state)
        StIdle: begin
          if (trigger) begin
            start_addr <= trig_start;
            end_addr   <= trig_start + SIZE'(LEN);
            busy       <= 1'b1;
            state      <= StWait;
          end
        end
        StWait: begin
          // The write landing at end_addr on this edge is outside the window.
          if (wr_ptr == end_addr) begin
            wr_hold  <= 1'b1;
            rb_rd_en <= 1'b1;
            rb_addr  <= start_addr;
            count    <= '0;
            state    <= StRead;
          end
        end
        StRead: begin
          if (load) begin
            dout       <= rb_data;
            dout_valid <= 1'b1;
            dout_last  <= last_load;
            rb_addr    <= rb_addr + 1'b1;
            count      <= count + 1'b1;
            if (last_load) begin
              rb_rd_en <= 1'b0;
              state    <= StDrain;
            end
          end
        end
        StDrain: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            wr_hold    <= 1'b0;
            busy       <= 1'b0;
            state      <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ringbuffer_readout.sv
// Bench for ringbuffer_readout: a ramp-fed ring buffer model plus a scoreboard of expected words.
module tb_ringbuffer_readout;

  localparam int SIZE  = 8;
  localparam int WIDTH = 14;
  localparam int PRE   = 16;
  localparam int LEN   = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             trigger = 1'b0;
  logic             wr_hold, rb_rd_en, dout_valid, dout_last, busy;
  logic             dout_ready = 1'b1;
  logic [SIZE-1:0]  rb_addr;
  logic [WIDTH-1:0] rb_data, dout;
  logic [7:0]       missed_trig;

  logic             trigger1 = 1'b0;
  logic             wr_hold1, rb_rd_en1, dout_valid1, dout_last1, busy1;
  logic             dout_ready1 = 1'b1;
  logic [SIZE-1:0]  rb_addr1;
  logic [WIDTH-1:0] rb_data1, dout1;
  logic [7:0]       missed_trig1;

  // Ring buffer model: writes the running sample index while neither reader holds it.
  logic [WIDTH-1:0] mem [0:255];
  logic [SIZE-1:0]  wr_ptr = '0;
  int               sample_idx = 0;

  always @(posedge clk) begin
    if (!(wr_hold || wr_hold1)) begin
      mem[wr_ptr] <= sample_idx[WIDTH-1:0];
      wr_ptr      <= wr_ptr + 8'd1;
      sample_idx  <= sample_idx + 1;
    end
  end

  assign rb_data  = mem[rb_addr];
  assign rb_data1 = mem[rb_addr1];

  ringbuffer_readout #(.SIZE(SIZE), .WIDTH(WIDTH), .PRE(PRE), .LEN(LEN)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .trigger    (trigger),
    .wr_ptr     (wr_ptr),
    .wr_hold    (wr_hold),
    .rb_rd_en   (rb_rd_en),
    .rb_addr    (rb_addr),
    .rb_data    (rb_data),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .busy       (busy),
    .missed_trig(missed_trig)
  );

  ringbuffer_readout #(.SIZE(SIZE), .WIDTH(WIDTH), .PRE(0), .LEN(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .trigger    (trigger1),
    .wr_ptr     (wr_ptr),
    .wr_hold    (wr_hold1),
    .rb_rd_en   (rb_rd_en1),
    .rb_addr    (rb_addr1),
    .rb_data    (rb_data1),
    .dout       (dout1),
    .dout_valid (dout_valid1),
    .dout_ready (dout_ready1),
    .dout_last  (dout_last1),
    .busy       (busy1),
    .missed_trig(missed_trig1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH:0]  exp_q[$];
  logic [SIZE-1:0] exp_start, exp_end, exp_hold_ptr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge: trigger fires on the next posedge with wr_ptr == ptr.
  task automatic fire(input logic [SIZE-1:0] ptr);
    int n = 0;
    int trig_idx;
    while (wr_ptr != ptr && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("fire_timeout", 1, 0);
    trig_idx     = sample_idx;
    exp_start    = ptr - 8'(PRE);
    exp_end      = exp_start + 8'(LEN);
    exp_hold_ptr = exp_end + 8'd1;
    for (int i = 0; i < LEN; i++) begin
      exp_q.push_back({(i == LEN - 1), WIDTH'(trig_idx - PRE + i)});
    end
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic drain(input bit bp, input bit inj, input int rst_at, input bit chk_start,
                       input bit timing);
    int cyc = 0, xfers = 0, rd_cyc = -1, first_x = -1, last_x = -1, nw = 0, nr = 0;
    bit seen_v = 0, stall = 0;
    logic [WIDTH:0] held, e;
    while (exp_q.size() > 0 && cyc < 3000) begin
      if (rst_at > 0 && xfers == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_valid", dout_valid, 0);
        check("rst_last", dout_last, 0);
        check("rst_dout", dout, 0);
        check("rst_hold", wr_hold, 0);
        check("rst_rden", rb_rd_en, 0);
        check("rst_addr", rb_addr, 0);
        check("rst_busy", busy, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (stall) begin
        check("stall_valid", dout_valid, 1);
        check("stall_word", {dout_last, dout}, held);
      end
      trigger    = 1'b0;
      dout_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rb_rd_en && rd_cyc < 0) begin
        rd_cyc = cyc;
        if (chk_start) begin
          check("start_addr", rb_addr, exp_start);
          check("hold_ptr", wr_ptr, exp_hold_ptr);
        end
      end
      if (dout_valid && !seen_v) begin
        seen_v = 1;
        if (timing) check("first_lat", cyc - rd_cyc, 1);
      end
      if (dout_valid && dout_ready) begin
        e = exp_q.pop_front();
        check("data", dout, e[WIDTH-1:0]);
        check("last", dout_last, e[WIDTH]);
        check("hold", wr_hold, 1);
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
        xfers++;
      end
      stall = dout_valid && !dout_ready;
      held  = {dout_last, dout};
      if (inj && busy && !rb_rd_en && !dout_valid && nw < 3 && cyc % 4 == 0) begin
        trigger = 1'b1;
        nw++;
      end else if (inj && rb_rd_en && nr < 2 && cyc % 8 == 0) begin
        trigger = 1'b1;
        nr++;
      end
      @(negedge clk);
      cyc++;
    end
    trigger    = 1'b0;
    dout_ready = 1'b1;
    if (cyc >= 3000) begin
      check("drain_timeout", 1, 0);
      exp_q.delete();
    end
    if (timing) check("burst_len", last_x - first_x, LEN - 1);
    @(negedge clk);
    check("end_busy", busy, 0);
    check("end_hold", wr_hold, 0);
    check("end_valid", dout_valid, 0);
  endtask

  initial begin
    int n;
    int idx1;
    bit extra;
    repeat (3) @(negedge clk);
    check("rst0_valid", dout_valid, 0);
    check("rst0_hold", wr_hold, 0);
    check("rst0_busy", busy, 0);
    check("rst0_missed", missed_trig, 0);
    rst = 1'b0;
    @(negedge clk);

    // PRE=0, LEN=1 instance: single word equal to the trigger-cycle sample.
    while (wr_ptr != 8'd10) @(negedge clk);
    idx1     = sample_idx;
    trigger1 = 1'b1;
    @(negedge clk);
    trigger1 = 1'b0;
    n = 0;
    while (!dout_valid1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("p0_valid", dout_valid1, 1);
    check("p0_data", dout1, 32'(idx1[WIDTH-1:0]));
    check("p0_last", dout_last1, 1);
    @(negedge clk);
    check("p0_done", {dout_valid1, busy1, rb_rd_en1}, 0);

    fire(8'd100);  // basic window: 84..147
    drain(0, 0, 0, 1, 1);
    fire(8'd30);   // backpressure
    drain(1, 0, 0, 1, 0);
    fire(8'd5);    // wrap-around: start 245
    drain(0, 0, 0, 1, 1);
    fire(8'd100);  // reset after 20 transfers
    drain(0, 0, 20, 1, 1);
    check("rst_missed", missed_trig, 0);
    fire(8'd180);
    drain(0, 0, 0, 1, 1);

    fire(8'd60);   // triggers while busy
    drain(0, 1, 0, 1, 1);
    check("missed5", missed_trig, 5);
    extra = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy || dout_valid) extra = 1;
    end
    check("one_window", extra, 0);

    fire(8'd120);  // saturate missed_trig
    dout_ready = 1'b0;
    n = 0;
    while (!dout_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("sat_valid", dout_valid, 1);
    trigger = 1'b1;
    repeat (300) @(negedge clk);
    trigger = 1'b0;
    check("missed_sat", missed_trig, 255);
    drain(0, 0, 0, 0, 0);
    check("dut1_missed", missed_trig1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
